game_tick_scheduler: RTL and testbench

//   Run/pause/stop sequencer for the 32-bit game clock. Turns gameTime into periodic per-channel

---
 rtl/game_sched_pkg.sv | 15 +
 rtl/sched_deadline_cmp.sv | 19 +
 rtl/game_tick_scheduler.sv | 157 +++++++++++++++
 tb/tb_game_tick_scheduler.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/game_sched_pkg.sv
// Shared types and defaults for the game tick scheduler: FSM state encoding
// and default channel count / time width.
package game_sched_pkg;

    localparam int NUM_CH_DEF = 4;
    localparam int TW_DEF     = 32;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CLEAR   = 2'd1,
        S_RUNNING = 2'd2,
        S_PAUSED  = 2'd3
    } sched_state_e;

endpackage

// File: rtl/sched_deadline_cmp.sv
// Wrap-safe deadline comparator: a channel is due once game time has reached
// its deadline, judged on the sign of the modular difference.
module sched_deadline_cmp #(
    parameter int TW = 32
) (
    input  logic [TW-1:0] game_time_i,
    input  logic [TW-1:0] deadline_i,
    input  logic [TW-1:0] period_i,
    output logic          fire_ok_o
);

    logic [TW-1:0] diff;

    // The sign bit of the modular difference stays correct across the 2^TW wrap
    // as long as the deadline is less than half the time range away.
    assign diff      = game_time_i - deadline_i;
    assign fire_ok_o = (period_i != '0) && !diff[TW-1];

endmodule

// File: rtl/game_tick_scheduler.sv
// Run/pause/stop sequencer for the game clock plus a round-robin scan that
// turns game time into periodic per-channel events using one shared comparator.
module game_tick_scheduler
    import game_sched_pkg::*;
#(
    parameter int NUM_CH = NUM_CH_DEF,
    parameter int CH_W   = 2,
    parameter int TW     = TW_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_start,
    input  logic              cmd_pause,
    input  logic              cmd_resume,
    input  logic              cmd_stop,
    input  logic [TW-1:0]     gameTime,
    output logic              game_run,
    output logic              game_clr,
    input  logic              cfg_wr,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [TW-1:0]     cfg_period,
    output logic [NUM_CH-1:0] evt_pending,
    input  logic [NUM_CH-1:0] evt_ack,
    output logic [NUM_CH-1:0] overrun,
    output logic [1:0]        state
);

    sched_state_e      state_q, state_d;
    logic              game_run_q, game_clr_q;
    logic [CH_W-1:0]   ptr_q, ptr_d;
    logic [TW-1:0]     period_q   [NUM_CH];
    logic [TW-1:0]     period_d   [NUM_CH];
    logic [TW-1:0]     deadline_q [NUM_CH];
    logic [TW-1:0]     deadline_d [NUM_CH];
    logic [NUM_CH-1:0] pending_q, pending_d;
    logic [NUM_CH-1:0] overrun_q, overrun_d;
    logic [NUM_CH-1:0] cfg_hit, fire;
    logic [TW-1:0]     scan_period, scan_deadline;
    logic              fire_ok, running, stop_clr;

    assign running  = (state_q == S_RUNNING);
    assign stop_clr = cmd_stop && (state_q != S_IDLE);

    // Stop dominates; otherwise only the command legal in the current state acts.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        state_d = state_q;
        if (cmd_stop) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:    if (cmd_start)  state_d = S_CLEAR;
                S_CLEAR:                   state_d = S_RUNNING;
                S_RUNNING: if (cmd_pause)  state_d = S_PAUSED;
                S_PAUSED:  if (cmd_resume) state_d = S_RUNNING;
                default:                   state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (running) begin
            ptr_d = (ptr_q == CH_W'(NUM_CH - 1)) ? '0 : ptr_q + 1'b1;
        end
    end

    always_comb begin
        scan_period   = '0;
        scan_deadline = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (ptr_q == CH_W'(i)) begin
                scan_period   = period_q[i];
                scan_deadline = deadline_q[i];
            end
        end
    end

    sched_deadline_cmp #(.TW(TW)) u_cmp (
        .game_time_i (gameTime),
        .deadline_i  (scan_deadline),
        .period_i    (scan_period),
        .fire_ok_o   (fire_ok)
    );

    // A config write on the scanned channel wins and drops that cycle's fire;
    // out-of-range cfg_ch matches no channel and is therefore ignored.
    always_comb begin
        cfg_hit   = '0;
        fire      = '0;
        pending_d = pending_q;
        overrun_d = overrun_q;
        for (int i = 0; i < NUM_CH; i++) begin
            period_d[i]   = period_q[i];
            deadline_d[i] = deadline_q[i];
            cfg_hit[i]    = cfg_wr && (cfg_ch == CH_W'(i));
            fire[i]       = running && (ptr_q == CH_W'(i)) && fire_ok && !cfg_hit[i];

            if (cfg_hit[i]) begin
                period_d[i]   = cfg_period;
                deadline_d[i] = gameTime + cfg_period;
            end else if (state_q == S_CLEAR) begin
                deadline_d[i] = period_q[i];
            end else if (fire[i]) begin
                deadline_d[i] = deadline_q[i] + period_q[i];
            end

            if (state_q == S_CLEAR) begin
                pending_d[i] = 1'b0;
                overrun_d[i] = 1'b0;
            end else begin
                if (fire[i]) begin
                    pending_d[i] = 1'b1;
                    if (pending_q[i] && !evt_ack[i]) overrun_d[i] = 1'b1;
                end else if (evt_ack[i]) begin
                    pending_d[i] = 1'b0;
                end
                if (stop_clr) pending_d[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            game_run_q <= 1'b0;
            game_clr_q <= 1'b0;
            ptr_q      <= '0;
            pending_q  <= '0;
            overrun_q  <= '0;
            // NOTE: the period/deadline arrays are architectural state with defined reset values, so they are reset like any other register.
            for (int i = 0; i < NUM_CH; i++) begin
                period_q[i]   <= '0;
                deadline_q[i] <= '0;
            end
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q    <= state_d;
            game_run_q <= (state_d == S_RUNNING);
            game_clr_q <= (state_d == S_CLEAR);
            ptr_q      <= ptr_d;
            pending_q  <= pending_d;
            overrun_q  <= overrun_d;
            for (int i = 0; i < NUM_CH; i++) begin
                period_q[i]   <= period_d[i];
                deadline_q[i] <= deadline_d[i];
            end
        end
    end

    assign game_run    = game_run_q;
    assign game_clr    = game_clr_q;
    assign evt_pending = pending_q;
    assign overrun     = overrun_q;
    assign state       = state_q;

endmodule

// File: tb/tb_game_tick_scheduler.sv
// Self-checking bench for game_tick_scheduler: directed scenarios plus a random
// phase, compared every cycle against a cycle-level model of the documented rules.
module tb_game_tick_scheduler;

    localparam int NCH = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        cmd_start = 1'b0, cmd_pause = 1'b0, cmd_resume = 1'b0, cmd_stop = 1'b0;
    logic [31:0] gt;
    logic        game_run, game_clr;
    logic        cfg_wr = 1'b0;
    logic [2:0]  cfg_ch = '0;   // one spare bit so out-of-range channels can be driven
    logic [31:0] cfg_period = '0;
    logic [3:0]  evt_pending, evt_ack = '0, overrun;
    logic [1:0]  state;

    logic        force_req = 1'b0;
    logic [31:0] force_val = '0;

    int checks   = 0;
    int failures = 0;

    // Model state
    int          m_state, m_ptr;
    logic [31:0] m_period [NCH];
    logic [31:0] m_dl     [NCH];
    logic [3:0]  m_pend, m_ovr;

    game_tick_scheduler #(.NUM_CH(4), .CH_W(3), .TW(32)) dut (
        .clk(clk), .reset(reset),
        .cmd_start(cmd_start), .cmd_pause(cmd_pause), .cmd_resume(cmd_resume), .cmd_stop(cmd_stop),
        .gameTime(gt), .game_run(game_run), .game_clr(game_clr),
        .cfg_wr(cfg_wr), .cfg_ch(cfg_ch), .cfg_period(cfg_period),
        .evt_pending(evt_pending), .evt_ack(evt_ack), .overrun(overrun), .state(state)
    );

    always #10 clk = ~clk;

    // Game clock counter driven by the scheduler outputs.
    always @(posedge clk or posedge reset) begin
        if (reset)          gt <= '0;
        else if (force_req) gt <= force_val;
        else if (game_clr)  gt <= '0;
        else if (game_run)  gt <= gt + 32'd1;
    end

    task automatic model_reset();
        m_state = 0;
        m_ptr   = 0;
        m_pend  = '0;
        m_ovr   = '0;
        for (int i = 0; i < NCH; i++) begin
            m_period[i] = '0;
            m_dl[i]     = '0;
        end
    endtask

    task automatic model_step();
        int          st;
        logic [31:0] diff;
        logic [3:0]  fired;
        st    = m_state;
        fired = '0;
        if (st == 2) begin
            diff = gt - m_dl[m_ptr];
            if (m_period[m_ptr] != 0 && $signed(diff) >= 0 && !(cfg_wr && cfg_ch == m_ptr))
                fired[m_ptr] = 1'b1;
            m_ptr = (m_ptr + 1) % NCH;
        end
        for (int i = 0; i < NCH; i++) begin
            if (cfg_wr && cfg_ch == i) begin
                m_period[i] = cfg_period;
                m_dl[i]     = gt + cfg_period;
            end else if (st == 1) begin
                m_dl[i] = m_period[i];
            end else if (fired[i]) begin
                m_dl[i] = m_dl[i] + m_period[i];
            end
            if (st == 1) begin
                m_pend[i] = 1'b0;
                m_ovr[i]  = 1'b0;
            end else begin
                if (fired[i] && m_pend[i] && !evt_ack[i]) m_ovr[i] = 1'b1;
                if (fired[i])        m_pend[i] = 1'b1;
                else if (evt_ack[i]) m_pend[i] = 1'b0;
                if (cmd_stop && st != 0) m_pend[i] = 1'b0;
            end
        end
        if (cmd_stop)                    st = 0;
        else if (cmd_start && st == 0)   st = 1;
        else if (st == 1)                st = 2;
        else if (cmd_pause && st == 2)   st = 3;
        else if (cmd_resume && st == 3)  st = 2;
        m_state = st;
    endtask

    always @(posedge clk or posedge reset) begin
        if (reset) model_reset();
        else       model_step();
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cmp_model();
        check("model_state",    {30'd0, state},    32'(m_state));
        check("model_game_run", {31'd0, game_run}, {31'd0, m_state == 2});
        check("model_game_clr", {31'd0, game_clr}, {31'd0, m_state == 1});
        check("model_pending",  {28'd0, evt_pending}, {28'd0, m_pend});
        check("model_overrun",  {28'd0, overrun},     {28'd0, m_ovr});
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
            cmp_model();
        end
    endtask

    task automatic cfg(input logic [2:0] ch, input logic [31:0] per);
        cfg_wr = 1'b1; cfg_ch = ch; cfg_period = per;
        tick();
        cfg_wr = 1'b0;
    endtask

    task automatic ack(input logic [3:0] mask);
        evt_ack = mask;
        tick();
        evt_ack = '0;
    endtask

    task automatic wait_gt(input logic [31:0] target, input string tag);
        int n = 0;
        while (gt !== target && n < 200) begin
            tick();
            n++;
        end
        check(tag, gt, target);
    endtask

    task automatic wait_pend(input int ch, input int bound, input string tag);
        int n = 0;
        while (evt_pending[ch] !== 1'b1 && n < bound) begin
            tick();
            n++;
        end
        check(tag, {31'd0, evt_pending[ch]}, 32'd1);
    endtask

    initial begin
        int base, spurious, n;

        // Reset state
        #3 reset = 1'b1;
        #4;
        check("rst_state", {30'd0, state}, 32'd0);
        check("rst_run_clr", {30'd0, game_run, game_clr}, 32'd0);
        check("rst_pend_ovr", {24'd0, evt_pending, overrun}, 32'd0);
        @(negedge clk) reset = 1'b0;
        tick(2);

        // 1: start sequencing and first fires of ch0
        cfg(3'd0, 32'd10);
        cmd_start = 1'b1;
        tick();
        cmd_start = 1'b0;
        check("t1_clear_state", {30'd0, state}, 32'd1);
        check("t1_clr_high", {30'd0, game_clr, game_run}, 32'b10);
        tick();
        check("t1_run_state", {30'd0, state}, 32'd2);
        check("t1_clr_one_cycle", {30'd0, game_clr, game_run}, 32'b01);
        wait_gt(32'd10, "t1_reach10");
        wait_pend(0, 4, "t1_fire10");
        ack(4'b0001);
        check("t1_acked", {31'd0, evt_pending[0]}, 32'd0);
        wait_gt(32'd20, "t1_reach20");
        wait_pend(0, 4, "t1_fire20");
        ack(4'b0001);

        // 2: overrun on unacked ch1; ack on a fire cycle of ch3 avoids overrun
        base = int'(gt);
        cfg(3'd1, 32'd5);
        wait_gt(32'(base + 15), "t2_reach");
        check("t2_pend1", {31'd0, evt_pending[1]}, 32'd1);
        check("t2_ovr1",  {31'd0, overrun[1]},     32'd1);
        cfg(3'd3, 32'd6);
        wait_pend(3, 12, "t2_fire3");
        n = 0;
        while (!(m_ptr == 3 && $signed(gt - m_dl[3]) >= 0) && n < 40) begin
            tick();
            n++;
        end
        check("t2_fire_window", 32'(n < 40), 32'd1);
        ack(4'b1000);
        check("t2_ack_on_fire_pend", {31'd0, evt_pending[3]}, 32'd1);
        check("t2_ack_on_fire_ovr",  {31'd0, overrun[3]},     32'd0);
        cfg(3'd1, 32'd0);
        cfg(3'd3, 32'd0);
        ack(4'b1111);

        // 4: stop with pause in the same cycle; restart keeps periods
        cmd_stop = 1'b1; cmd_pause = 1'b1;
        tick();
        cmd_stop = 1'b0; cmd_pause = 1'b0;
        check("t4_idle", {30'd0, state}, 32'd0);
        check("t4_pend_clr", {28'd0, evt_pending}, 32'd0);
        check("t4_run_off", {31'd0, game_run}, 32'd0);
        cmd_start = 1'b1;
        tick();
        cmd_start = 1'b0;
        tick();
        check("t4_restart", {30'd0, state}, 32'd2);

        // 3: pause at gameTime 7 for 50 cycles
        wait_gt(32'd6, "t3_reach6");
        cmd_pause = 1'b1;
        tick();
        cmd_pause = 1'b0;
        check("t3_paused", {30'd0, state, game_run}, 32'b110);
        tick(50);
        check("t3_frozen", gt, 32'd7);
        check("t3_no_evt", {28'd0, evt_pending}, 32'd0);
        cmd_resume = 1'b1;
        tick();
        cmd_resume = 1'b0;
        check("t3_resumed", {30'd0, state}, 32'd2);
        wait_gt(32'd10, "t3_reach10");
        wait_pend(0, 4, "t3_fire10");
        cfg(3'd0, 32'd0);
        ack(4'b0001);

        // 5: wrap across 2^32
        force_val = 32'hFFFF_FFF4;
        force_req = 1'b1;
        tick();
        force_req = 1'b0;
        check("t5_forced", gt, 32'hFFFF_FFF4);
        cfg(3'd2, 32'd8);
        wait_gt(32'hFFFF_FFFC, "t5_reach_fffc");
        wait_pend(2, 4, "t5_fire_fffc");
        ack(4'b0100);
        spurious = 0;
        n = 0;
        while (gt !== 32'd4 && n < 40) begin
            tick();
            if (evt_pending[2]) spurious++;
            n++;
        end
        check("t5_reach4", gt, 32'd4);
        check("t5_no_spurious", 32'(spurious), 32'd0);
        wait_pend(2, 4, "t5_fire_4");

        // 6: disable while pending; out-of-range channel ignored
        cfg(3'd2, 32'd0);
        tick(30);
        check("t6_pend_kept", {31'd0, evt_pending[2]}, 32'd1);
        check("t6_no_ovr",    {31'd0, overrun[2]},     32'd0);
        ack(4'b0100);
        check("t6_acked", {31'd0, evt_pending[2]}, 32'd0);
        cfg(3'd7, 32'd3);
        tick(20);
        check("t6_ch7_ignored", {28'd0, evt_pending}, 32'd0);

        // Random phase
        for (int c = 0; c < 400; c++) begin
            cfg_wr     = ($urandom_range(0, 7) == 0);
            cfg_ch     = 3'($urandom_range(0, 7));
            cfg_period = 32'($urandom_range(0, 12));
            evt_ack    = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'd0;
            cmd_stop   = ($urandom_range(0, 59) == 0);
            cmd_start  = ($urandom_range(0, 9) == 0);
            cmd_pause  = ($urandom_range(0, 24) == 0);
            cmd_resume = ($urandom_range(0, 9) == 0);
            tick();
        end
        {cfg_wr, cmd_stop, cmd_start, cmd_pause, cmd_resume} = '0;
        evt_ack = '0;

        // Reset in mid-operation
        cmd_start = 1'b1;
        tick(3);
        cmd_start = 1'b0;
        reset = 1'b1;
        #2;
        check("mid_rst_state", {30'd0, state}, 32'd0);
        check("mid_rst_outs", {22'd0, game_run, game_clr, evt_pending, overrun}, 32'd0);
        cmp_model();
        @(negedge clk) reset = 1'b0;
        tick(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
